// File: rtl/fc_evt_pkg.sv
// Shared types, defaults and the round-robin picker for the FC event queue.
package fc_evt_pkg;

  localparam int unsigned DEFAULT_EVENT_ID_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH     = 8;
  localparam int unsigned MAX_NB_EVT             = 64;

  typedef logic [DEFAULT_EVENT_ID_WIDTH-1:0] evt_id_t;

  // One-hot grant of the first set request at or after ptr, wrapping over 64 slots.
  // Unused request bits are zero, so wrapping at 64 behaves like wrapping at NB_EVT.
  function automatic logic [MAX_NB_EVT-1:0] rr_pick(input logic [MAX_NB_EVT-1:0] req,
                                                    input logic [5:0]            ptr);
    logic [MAX_NB_EVT-1:0] gnt;
    logic                  found;
    logic [5:0]            idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      idx = ptr + 6'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fc_evt_fifo.sv
// Power-of-two ID FIFO; head is shown on data_o, which reads 0 while empty.
module fc_evt_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     pop_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [LW-1:0]         level_q;
  logic                  do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (!do_push && do_pop) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/fc_event_queue.sv
// Latches SoC event pulses, grants one round-robin per cycle and queues its ID for the FC event port.
// Optional feature macro: FC_EVT_OVERFLOW_CNT_EN adds the saturating lost-event counter overflow_cnt_o.
module fc_event_queue
  import fc_evt_pkg::*;
#(
  parameter int unsigned NB_EVT         = 32,
  parameter int unsigned EVENT_ID_WIDTH = DEFAULT_EVENT_ID_WIDTH,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned ID_OFFSET      = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_EVT-1:0]             evt_i,
  input  logic [NB_EVT-1:0]             evt_mask_i,
  output logic                          event_fifo_valid_o,
  input  logic                          event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0]     event_fifo_data_o,
  output logic [NB_EVT-1:0]             lost_o,
  input  logic [NB_EVT-1:0]             lost_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
`ifdef FC_EVT_OVERFLOW_CNT_EN
  ,
  output logic [15:0]                   overflow_cnt_o
`endif
);

  localparam int unsigned IW = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;

  if (NB_EVT < 1 || NB_EVT > MAX_NB_EVT) begin : g_bad_nb_evt
    $error("fc_event_queue: NB_EVT must be in 1..64");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fc_event_queue: FIFO_DEPTH must be a power of 2 >= 2");
  end
  if (EVENT_ID_WIDTH < 64 &&
      (64'(ID_OFFSET) + 64'(NB_EVT) - 64'd1) >= (64'd1 << EVENT_ID_WIDTH)) begin : g_bad_id
    $error("fc_event_queue: ID_OFFSET+NB_EVT-1 does not fit in EVENT_ID_WIDTH");
  end

  logic [NB_EVT-1:0]         pending_q, lost_q;
  logic [NB_EVT-1:0]         hit_c, grant_c, new_lost_c;
  logic [IW-1:0]             rr_ptr_q, gnt_idx_c;
  logic [MAX_NB_EVT-1:0]     gnt_ext_c;
  logic                      gnt_any_c, push_ok_c, pop_c;
  logic                      fifo_full, fifo_empty;
  logic [EVENT_ID_WIDTH-1:0] id_c;

  assign pop_c     = ~fifo_empty & event_fifo_fulln_i;
  assign push_ok_c = ~fifo_full | pop_c;
  assign hit_c     = evt_i & evt_mask_i;

  // Arbitration is suppressed entirely when the FIFO cannot take an entry.
  always_comb begin
    gnt_ext_c = rr_pick(64'(pending_q), 6'(rr_ptr_q));
    gnt_any_c = push_ok_c & (|gnt_ext_c);
    grant_c   = push_ok_c ? gnt_ext_c[NB_EVT-1:0] : '0;
    gnt_idx_c = '0;
    for (int i = 0; i < NB_EVT; i++) begin
      if (grant_c[i]) gnt_idx_c = IW'(i);
    end
    id_c       = EVENT_ID_WIDTH'(ID_OFFSET + 32'(gnt_idx_c));
    new_lost_c = hit_c & pending_q & ~grant_c;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      lost_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= (pending_q & ~grant_c) | hit_c;
      lost_q    <= (lost_q & ~lost_clr_i) | new_lost_c;
      if (gnt_any_c) rr_ptr_q <= (gnt_idx_c == IW'(NB_EVT - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

  assign lost_o             = lost_q;
  assign event_fifo_valid_o = ~fifo_empty;

  fc_evt_fifo #(
    .DATA_WIDTH (EVENT_ID_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_any_c),
    .data_i  (id_c),
    .pop_i   (pop_c),
    .data_o  (event_fifo_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

`ifdef FC_EVT_OVERFLOW_CNT_EN
  logic [16:0] cnt_sum_c;

  assign cnt_sum_c = 17'(overflow_cnt_o) + 17'($countones(new_lost_c));

  always_ff @(posedge clk_i) begin
    if (!rst_ni)          overflow_cnt_o <= '0;
    else if (|lost_clr_i) overflow_cnt_o <= '0;
    else if (cnt_sum_c[16]) overflow_cnt_o <= 16'hFFFF;
    else                  overflow_cnt_o <= cnt_sum_c[15:0];
  end
`endif

endmodule

// File: tb/tb_fc_event_queue.sv
// Self-checking bench for fc_event_queue: directed table, corner sequences and randomized model comparison.
module tb_fc_event_queue;
  import fc_evt_pkg::*;

  localparam int NB    = 32;
  localparam int DEPTH = 8;
  localparam int OFS1  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] evt, mask, lost_clr;
  logic          fulln;
  logic          valid0, valid1;
  evt_id_t       data0, data1;
  logic [NB-1:0] lost0, lost1;
  logic [3:0]    level0, level1;
`ifdef FC_EVT_OVERFLOW_CNT_EN
  logic [15:0]   cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  fc_event_queue #(.NB_EVT(NB), .EVENT_ID_WIDTH(8), .FIFO_DEPTH(DEPTH), .ID_OFFSET(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt), .evt_mask_i(mask),
    .event_fifo_valid_o(valid0), .event_fifo_fulln_i(fulln), .event_fifo_data_o(data0),
    .lost_o(lost0), .lost_clr_i(lost_clr), .level_o(level0)
`ifdef FC_EVT_OVERFLOW_CNT_EN
    , .overflow_cnt_o(cnt0)
`endif
  );

  fc_event_queue #(.NB_EVT(NB), .EVENT_ID_WIDTH(8), .FIFO_DEPTH(DEPTH), .ID_OFFSET(OFS1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt), .evt_mask_i(mask),
    .event_fifo_valid_o(valid1), .event_fifo_fulln_i(fulln), .event_fifo_data_o(data1),
    .lost_o(lost1), .lost_clr_i(lost_clr), .level_o(level1)
`ifdef FC_EVT_OVERFLOW_CNT_EN
    , .overflow_cnt_o(cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: pending set, pointer, ID queue and sticky flags evolved from the rules directly.
  logic [NB-1:0] m_pend, m_lost;
  int            m_ptr;
  int            m_q[$];
  int            m_cnt;

  function automatic void model_step(input logic r, input logic [NB-1:0] e, input logic [NB-1:0] m,
                                     input logic f, input logic [NB-1:0] clr);
    bit pop, can;
    int g, n;
    if (!r) begin
      m_pend = '0; m_lost = '0; m_ptr = 0; m_q.delete(); m_cnt = 0;
      return;
    end
    pop = (m_q.size() > 0) && f;
    can = (m_q.size() < DEPTH) || pop;
    g = -1;
    if (can) begin
      for (int k = 0; k < NB; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % NB;
    end
    m_lost = m_lost & ~clr;
    n = 0;
    for (int i = 0; i < NB; i++) begin
      if (e[i] && m[i]) begin
        if (m_pend[i]) begin
          m_lost[i] = 1'b1;
          n++;
        end
        m_pend[i] = 1'b1;
      end
    end
    if (|clr) m_cnt = 0;
    else m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
  endfunction

  task automatic compare_model();
    chk("valid0", valid0, m_q.size() != 0);
    chk("valid1", valid1, m_q.size() != 0);
    chk("data0", data0, (m_q.size() != 0) ? m_q[0] : 0);
    chk("data1", data1, (m_q.size() != 0) ? m_q[0] + OFS1 : 0);
    chk("level", level0, m_q.size());
    chk("lost", lost0, m_lost);
`ifdef FC_EVT_OVERFLOW_CNT_EN
    chk("ovf_cnt", cnt0, m_cnt);
`endif
  endtask

  task automatic cycle(input logic r, input logic [NB-1:0] e, input logic [NB-1:0] m,
                       input logic f, input logic [NB-1:0] clr);
    rst_n = r; evt = e; mask = m; fulln = f; lost_clr = clr;
    @(posedge clk);
    model_step(r, e, m, f, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, '1, '1, 1'b1, '0);
    cycle(1'b0, '1, '1, 1'b1, '0);
  endtask

  typedef struct {
    logic          rst_n;
    logic [NB-1:0] evt;
    logic          valid;
    logic [7:0]    data;
    logic [3:0]    level;
  } tv_t;

  tv_t tv[11];
  int  got_ids[$];

  initial begin
    rst_n = 1'b0; evt = '0; mask = '1; fulln = 1'b1; lost_clr = '0;

    // Reset with all pulses high, single pulse on source 5, then three simultaneous pulses.
    tv[0]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 8'd0, 4'd0};
    tv[1]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 8'd0, 4'd0};
    tv[2]  = '{1'b1, 32'h0000_0020, 1'b0, 8'd0, 4'd0};
    tv[3]  = '{1'b1, 32'h0000_0000, 1'b1, 8'd5, 4'd1};
    tv[4]  = '{1'b1, 32'h0000_0000, 1'b0, 8'd0, 4'd0};
    tv[5]  = '{1'b0, 32'h0000_0000, 1'b0, 8'd0, 4'd0};
    tv[6]  = '{1'b1, 32'h0000_0111, 1'b0, 8'd0, 4'd0};
    tv[7]  = '{1'b1, 32'h0000_0000, 1'b1, 8'd0, 4'd1};
    tv[8]  = '{1'b1, 32'h0000_0000, 1'b1, 8'd4, 4'd1};
    tv[9]  = '{1'b1, 32'h0000_0000, 1'b1, 8'd8, 4'd1};
    tv[10] = '{1'b1, 32'h0000_0000, 1'b0, 8'd0, 4'd0};
    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].rst_n, tv[i].evt, '1, 1'b1, '0);
      chk($sformatf("tv%0d_valid", i), valid0, tv[i].valid);
      chk($sformatf("tv%0d_data", i), data0, tv[i].data);
      chk($sformatf("tv%0d_data_ofs", i), data1, tv[i].valid ? tv[i].data + 8'd16 : 8'd0);
      chk($sformatf("tv%0d_level", i), level0, tv[i].level);
      chk($sformatf("tv%0d_lost", i), lost0, 0);
    end

    // Fill with fulln low: 8 queued, ninth stays pending, a repeat pulse is lost, then drain.
    do_reset();
    cycle(1'b1, 32'h1FF, '1, 1'b0, '0);
    for (int i = 0; i < 9; i++) cycle(1'b1, '0, '1, 1'b0, '0);
    chk("full_level", level0, 8);
    cycle(1'b1, 32'h100, '1, 1'b0, '0);
    chk("lost_src8", lost0, 32'h100);
    for (int k = 0; k < 20; k++) begin
      if (valid0) got_ids.push_back(int'(data0));
      cycle(1'b1, '0, '1, 1'b1, '0);
    end
    chk("drain_count", got_ids.size(), 9);
    for (int i = 0; i < got_ids.size() && i < 9; i++) chk($sformatf("drain_id%0d", i), got_ids[i], i);
    chk("drain_level", level0, 0);

    // Full FIFO with simultaneous pop and push, then clear colliding with a new loss.
    do_reset();
    cycle(1'b1, 32'h1FF, '1, 1'b0, '0);
    for (int i = 0; i < 9; i++) cycle(1'b1, '0, '1, 1'b0, '0);
    cycle(1'b1, 32'h0010_0000, '1, 1'b1, '0);
    chk("pushpop_level", level0, 8);
    cycle(1'b1, 32'h0010_0000, '1, 1'b0, '0);
    chk("lost20_set", lost0[20], 1'b1);
    cycle(1'b1, '0, '1, 1'b0, 32'h0010_0000);
    chk("lost20_clr", lost0[20], 1'b0);
    cycle(1'b1, 32'h0010_0000, '1, 1'b0, 32'h0010_0000);
    chk("lost20_wins", lost0[20], 1'b1);

`ifdef FC_EVT_OVERFLOW_CNT_EN
    do_reset();
    for (int k = 0; k < 3000 && m_cnt < 65535; k++) cycle(1'b1, '1, '1, 1'b0, '0);
    for (int k = 0; k < 3; k++) cycle(1'b1, '1, '1, 1'b0, '0);
    chk("ovf_saturate", cnt0, 16'hFFFF);
    cycle(1'b1, '0, '1, 1'b0, 32'h1);
    chk("ovf_cleared", cnt0, 16'h0);
`endif

    // Randomized traffic against the model, including mask changes and occasional resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [NB-1:0] e, m, c;
      e = (k % 64 < 16) ? ($urandom() & $urandom()) : ($urandom() & $urandom() & $urandom() & $urandom());
      m = $urandom() | $urandom();
      c = ($urandom_range(0, 15) == 0) ? NB'($urandom()) : '0;
      cycle(($urandom_range(0, 499) != 0), e, m, ($urandom_range(0, 3) != 0), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
